// File: rtl/block_pe_param_if.sv
// rtl/block_pe_param_if.sv - PE data channel bundle: per-channel inputs with valids, result with valid.
interface block_pe_param_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 2
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [WIDTH-1:0]        out0;
   logic                    out_valid;

   modport master (output in_data, output in_valid, input out0, input out_valid);
   modport slave  (input in_data, input in_valid, output out0, output out_valid);
endinterface

// File: rtl/block_pe_param.sv
// rtl/block_pe_param.sv - parametrised CGRA PE: operand crossbar, ALU with MAC, DEPTH-word memory.
// Configuration arrives over a serial scan chain clocked by the datapath clock.
module block_pe_param #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 2,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              config_en,
   input  logic              config_in,
   output logic              config_out,
   block_pe_param_if.slave   pe
);
   localparam int AW    = $clog2(DEPTH);
   localparam int SELW  = $clog2(NUM_IN + 2);
   localparam int CFG_W = 4 * SELW + 4 + 1 + 2 + 1;
   localparam int NSRC  = NUM_IN + 2;

   logic [CFG_W-1:0] cfg_q;
   logic [WIDTH-1:0] alu_q, alu_d, acc_q, acc_d, mem_q, out_q;
   logic             alu_v_q, alu_v_d, mem_v_q, out_v_q;
   logic [WIDTH-1:0] mem [DEPTH];

   logic [SELW-1:0] sel_a, sel_b, sel_addr, sel_data;
   logic [3:0]      alu_op;
   logic            mem_we, out_reg;
   logic [1:0]      out_sel;

   assign sel_a    = cfg_q[0*SELW +: SELW];
   assign sel_b    = cfg_q[1*SELW +: SELW];
   assign sel_addr = cfg_q[2*SELW +: SELW];
   assign sel_data = cfg_q[3*SELW +: SELW];
   assign alu_op   = cfg_q[4*SELW +: 4];
   assign mem_we   = cfg_q[4*SELW + 4];
   assign out_sel  = cfg_q[4*SELW + 5 +: 2];
   assign out_reg  = cfg_q[4*SELW + 7];
   assign config_out = cfg_q[0];

   // Crossbar sources: external channels, then the two feedback registers.
   logic [NSRC-1:0][WIDTH-1:0] src_d;
   logic [NSRC-1:0]            src_v;

   always_comb begin
      src_d = '0;
      src_v = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         src_d[i] = pe.in_data[i*WIDTH +: WIDTH];
         src_v[i] = pe.in_valid[i];
      end
      src_d[NUM_IN]     = alu_q;
      src_v[NUM_IN]     = alu_v_q;
      src_d[NUM_IN + 1] = mem_q;
      src_v[NUM_IN + 1] = mem_v_q;
   end

   function automatic logic [WIDTH:0] pick(input logic [SELW-1:0] s,
                                           input logic [NSRC-1:0][WIDTH-1:0] d,
                                           input logic [NSRC-1:0] v);
      if (32'(s) < NSRC) return {v[s], d[s]};
      return {1'b1, {WIDTH{1'b0}}};
   endfunction

   logic [WIDTH-1:0] a_op, b_op, addr_op, data_op;
   logic             v_a, v_b, v_addr, v_data;
   logic             fire, mfire, mem_wr, mem_rd;
   logic [AW-1:0]    mem_addr;

   assign {v_a, a_op}       = pick(sel_a, src_d, src_v);
   assign {v_b, b_op}       = pick(sel_b, src_d, src_v);
   assign {v_addr, addr_op} = pick(sel_addr, src_d, src_v);
   assign {v_data, data_op} = pick(sel_data, src_d, src_v);

   assign fire     = v_a & v_b & ~config_en;
   assign mfire    = v_addr & v_data & ~config_en;
   assign mem_addr = addr_op[AW-1:0];
   assign mem_wr   = mem_we & mfire;
   assign mem_rd   = ~mem_we & v_addr & ~config_en;

   // Upper address bits are intentionally ignored so addresses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, addr_op[WIDTH-1:AW]};

   always_comb begin
      alu_d   = alu_q;
      acc_d   = acc_q;
      alu_v_d = 1'b0;
      if (fire) begin
         alu_v_d = 1'b1;
         case (alu_op)
            4'd0:    alu_d = a_op + b_op;
            4'd1:    alu_d = a_op - b_op;
            4'd2:    alu_d = a_op & b_op;
            4'd3:    alu_d = a_op | b_op;
            4'd4:    alu_d = a_op ^ b_op;
            4'd5:    alu_d = a_op << b_op;
            4'd6:    alu_d = a_op >> b_op;
            4'd7:    alu_d = a_op * b_op;
            4'd8: begin
               acc_d = acc_q + a_op * b_op;
               alu_d = acc_d;
            end
            4'd9:    alu_d = {{(WIDTH-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
            4'd10: begin
               acc_d = '0;
               alu_d = a_op;
            end
            default: alu_d = a_op;
         endcase
      end
   end

   logic [WIDTH-1:0] mux_d;
   logic             mux_v;

   always_comb begin
      mux_d = '0;
      mux_v = 1'b0;
      case (out_sel)
         2'd0:    begin mux_d = alu_q; mux_v = alu_v_q; end
         2'd1:    begin mux_d = mem_q; mux_v = mem_v_q; end
         2'd2:    begin mux_d = a_op;  mux_v = v_a;     end
         default: begin mux_d = '0;    mux_v = 1'b0;    end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= data_op;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_q   <= '0;
         acc_q   <= '0;
         alu_q   <= '0;
         alu_v_q <= 1'b0;
         mem_q   <= '0;
         mem_v_q <= 1'b0;
         out_q   <= '0;
         out_v_q <= 1'b0;
      end else begin
         if (config_en) cfg_q <= {config_in, cfg_q[CFG_W-1:1]};
         acc_q   <= acc_d;
         alu_q   <= alu_d;
         alu_v_q <= alu_v_d;
         if (mem_rd) mem_q <= mem[mem_addr];
         mem_v_q <= mem_rd;
         if (!config_en) out_q <= mux_d;
         out_v_q <= mux_v & ~config_en;
      end
   end

   assign pe.out0      = out_reg ? out_q : mux_d;
   assign pe.out_valid = (out_reg ? out_v_q : mux_v) & ~config_en;
endmodule
